seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//  Registered, handshaked ALU; parametrised successor of the combinational add/mul ALU.
//  Ops: ADD, SUB (1-cycle), unsigned/signed MUL (iterative shift-add, WIDTH cycles).
//  Sits between operand issue logic and result writeback; one op in flight at a time.
//  Adds carry/borrow, signed-overflow, zero flags and a pass-through tag.
// PARAMETERS
//  WIDTH  32  operand width in bits (>=2); result is 2*WIDTH
//  TAG_W  4   width of the opaque tag carried from request to result
// PORTS
//  clk        in   1          clock, all state updates on rising edge
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          request valid
//  in_ready   out  1          request accepted when in_valid && in_ready
//  op         in   2          00 ADD, 01 SUB, 10 MULU, 11 MULS
//  A          in   WIDTH      operand A
//  B          in   WIDTH      operand B
//  tag_in     in   TAG_W      request tag
//  out_valid  out  1          result valid; held until out_ready
//  out_ready  in   1          result consumed when out_valid && out_ready
//  ALU_Out    out  2*WIDTH    result
//  carry      out  1          ADD: carry-out; SUB: borrow (A<B unsigned); MUL: 0
//  ovf        out  1          ADD/SUB: two's-complement overflow; MUL: 0
//  zero       out  1          ALU_Out == 0
//  tag_out    out  TAG_W      tag of the op producing ALU_Out
// BEHAVIOUR
//  States: IDLE, MUL, DONE.  in_ready = (state==IDLE); no accept in MUL/DONE.
//  Reset (any state, incl. mid-MUL): state<=IDLE; out_valid, ALU_Out, carry, ovf, zero,
//   tag_out, counter, accumulators <= 0. In-flight op is dropped, no result emitted.
//  IDLE, accept ADD/SUB: result computed from captured A/B, registered; next state DONE.
//   out_valid rises 1 cycle after accept edge. ALU_Out[2W-1:W]=0, [W-1:0]=sum/diff.
//   ovf = operand signs equal (ADD) / differ (SUB) and result sign differs from A.
//  IDLE, accept MULU/MULS: latch multiplicand, multiplier, sign = A[W-1]^B[W-1] (MULS only,
//   operands replaced by magnitudes); cnt<=WIDTH; state MUL.
//  MUL: each cycle add multiplicand to acc if multiplier LSB, shift; cnt--. At cnt==1
//   step, load result (negated if MULS && sign) into ALU_Out; state DONE.
//   out_valid rises exactly WIDTH+1 cycles after accept edge. Full 2*WIDTH product.
//  MULS of most-negative operands handled via unsigned magnitude (2^(W-1)); no overflow.
//  DONE: outputs stable while out_valid && !out_ready. On out_ready: state IDLE,
//   out_valid<=0 next cycle; in_ready high that same next cycle (min 1 bubble between ops).
//  zero computed from the registered ALU_Out value; flags/tag change only on result load.
//  Inputs A/B/op/tag_in are don't-care except on the accept cycle.
// TESTING (WIDTH=32)
//  ADD FFFFFFFF+00000001 -> 1 cycle later ALU_Out=0, carry=1, zero=1, ovf=0.
//  ADD 7FFFFFFF+1 -> ALU_Out=0000000080000000, ovf=1, carry=0; SUB 5-7 -> FFFFFFFE, carry=1.
//  MULU FFFFFFFF*FFFFFFFF -> out_valid at accept+33, ALU_Out=FFFFFFFE00000001, tag matches.
//  MULS FFFFFFFD(-3)*00000005 -> FFFFFFFFFFFFFFF1; MULS 80000000*80000000 -> 4000000000000000.
//  Hold out_ready=0 for 10 cycles after result: ALU_Out/flags stable, in_ready=0; then release.
//  Assert rst at cycle 10 of a MUL: all outputs 0, IDLE next cycle; following ADD 2+3 -> 5.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/result handshake bundle for seq_alu: operands and tag flow in,
// the registered 2*WIDTH result with flags and tag flows back out.
interface seq_alu_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [TAG_W-1:0]     tag_in;

    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   ALU_Out;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic [TAG_W-1:0]     tag_out;

    // Issue/writeback side.
    modport master (
        output in_valid, op, A, B, tag_in, out_ready,
        input  in_ready, out_valid, ALU_Out, carry, ovf, zero, tag_out
    );

    // ALU side.
    modport slave (
        input  in_valid, op, A, B, tag_in, out_ready,
        output in_ready, out_valid, ALU_Out, carry, ovf, zero, tag_out
    );
endinterface

// File: rtl/seq_alu.sv
// Registered, handshaked ALU: single-cycle ADD/SUB and an iterative shift-add
// unsigned/signed multiplier producing a full 2*WIDTH product, one op in flight.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MULU = 2'b10;
    localparam logic [1:0] OP_MULS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_reg,     state_next;
    logic [CW-1:0]        cnt_reg,       cnt_next;
    logic [2*WIDTH-1:0]   mcand_reg,     mcand_next;
    logic [WIDTH-1:0]     mplier_reg,    mplier_next;
    logic [2*WIDTH-1:0]   acc_reg,       acc_next;
    logic                 sign_reg,      sign_next;
    logic [TAG_W-1:0]     tag_pend_reg,  tag_pend_next;

    logic                 out_valid_reg, out_valid_next;
    logic [2*WIDTH-1:0]   result_reg,    result_next;
    logic                 carry_reg,     carry_next;
    logic                 ovf_reg,       ovf_next;
    logic                 zero_reg,      zero_next;
    logic [TAG_W-1:0]     tag_out_reg,   tag_out_next;

    // Operand-side arithmetic, only meaningful on the accept cycle.
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH:0]       diff_ext;
    logic                 is_muls;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 add_ovf;
    logic                 sub_ovf;

    assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
    // The extra top bit of a zero-extended subtraction is the unsigned borrow.
    assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};
    assign is_muls  = (bus.op == OP_MULS);

    // Magnitudes for signed multiply; -2^(W-1) maps onto itself as an unsigned value.
    assign mag_a = (is_muls && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign mag_b = (is_muls && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                     (sum_ext[WIDTH-1] != bus.A[WIDTH-1]);
    assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                     (diff_ext[WIDTH-1] != bus.A[WIDTH-1]);

    // Partial product for this step: the shifted multiplicand gated by the multiplier LSB.
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [2*WIDTH-1:0]   product_final;

    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    assign acc_sum       = acc_reg + addend;
    assign product_final = sign_reg ? -acc_sum : acc_sum;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mcand_next     = mcand_reg;
        mplier_next    = mplier_reg;
        acc_next       = acc_reg;
        sign_next      = sign_reg;
        tag_pend_next  = tag_pend_reg;
        out_valid_next = out_valid_reg;
        result_next    = result_reg;
        carry_next     = carry_reg;
        ovf_next       = ovf_reg;
        zero_next      = zero_reg;
        tag_out_next   = tag_out_reg;

        unique case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    tag_pend_next = bus.tag_in;
                    unique case (bus.op)
                        OP_ADD: begin
                            result_next    = {{WIDTH{1'b0}}, sum_ext[WIDTH-1:0]};
                            carry_next     = sum_ext[WIDTH];
                            ovf_next       = add_ovf;
                            zero_next      = (sum_ext[WIDTH-1:0] == '0);
                            tag_out_next   = bus.tag_in;
                            out_valid_next = 1'b1;
                            state_next     = DONE;
                        end
                        OP_SUB: begin
                            result_next    = {{WIDTH{1'b0}}, diff_ext[WIDTH-1:0]};
                            carry_next     = diff_ext[WIDTH];
                            ovf_next       = sub_ovf;
                            zero_next      = (diff_ext[WIDTH-1:0] == '0);
                            tag_out_next   = bus.tag_in;
                            out_valid_next = 1'b1;
                            state_next     = DONE;
                        end
                        OP_MULU, OP_MULS: begin
                            mcand_next  = {{WIDTH{1'b0}}, mag_a};
                            mplier_next = mag_b;
                            acc_next    = '0;
                            sign_next   = is_muls && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                            cnt_next    = CNT_FULL;
                            state_next  = MUL;
                        end
                        default: ;
                    endcase
                end
            end

            MUL: begin
                acc_next    = acc_sum;
                mcand_next  = {mcand_reg[2*WIDTH-2:0], 1'b0};
                mplier_next = {1'b0, mplier_reg[WIDTH-1:1]};
                cnt_next    = cnt_reg - CNT_ONE;
                // The last step folds its partial product straight into the result.
                if (cnt_reg == CNT_ONE) begin
                    result_next    = product_final;
                    carry_next     = 1'b0;
                    ovf_next       = 1'b0;
                    zero_next      = (acc_sum == '0);
                    tag_out_next   = tag_pend_reg;
                    out_valid_next = 1'b1;
                    state_next     = DONE;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            sign_reg      <= 1'b0;
            tag_pend_reg  <= '0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            ovf_reg       <= 1'b0;
            zero_reg      <= 1'b0;
            tag_out_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mcand_reg     <= mcand_next;
            mplier_reg    <= mplier_next;
            acc_reg       <= acc_next;
            sign_reg      <= sign_next;
            tag_pend_reg  <= tag_pend_next;
            out_valid_reg <= out_valid_next;
            result_reg    <= result_next;
            carry_reg     <= carry_next;
            ovf_reg       <= ovf_next;
            zero_reg      <= zero_next;
            tag_out_reg   <= tag_out_next;
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.ALU_Out   = result_reg;
    assign bus.carry     = carry_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.zero      = zero_reg;
    assign bus.tag_out   = tag_out_reg;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed corner cases, backpressure,
// mid-multiply reset and randomized ops against a plain-arithmetic reference model.
module tb_seq_alu;
    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int MUL_LAT = WIDTH + 1;
    localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MIN_S = -64'sh0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    seq_alu_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    seq_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: {result[63:0], carry, ovf, zero, tag[3:0]} from ordinary integer arithmetic.
    function automatic logic [70:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] t);
        logic [63:0] res;
        logic [32:0] s;
        logic        c, v;
        longint      sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (o)
            2'b00: begin
                s   = {1'b0, a} + {1'b0, b};
                res = {32'b0, s[31:0]};
                c   = s[32];
                r   = sa + sb;
                v   = (r > MAX_S) || (r < MIN_S);
            end
            2'b01: begin
                res = {32'b0, a - b};
                c   = (a < b);
                r   = sa - sb;
                v   = (r > MAX_S) || (r < MIN_S);
            end
            2'b10: res = {32'b0, a} * {32'b0, b};
            default: begin
                r   = sa * sb;
                res = r;
            end
        endcase
        return {res, c, v, (res == 64'd0), t};
    endfunction

    function automatic logic [70:0] observed();
        return {bus.ALU_Out, bus.carry, bus.ovf, bus.zero, bus.tag_out};
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, output bit ok);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = bus.in_ready;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.A = a;
        bus.B = b;
        bus.tag_in = t;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op = 2'($urandom);
        bus.A = $urandom;
        bus.B = $urandom;
        bus.tag_in = 4'($urandom);
    endtask

    // Latency counted in negedges after the accept edge, 1 = first sample after accept.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (observed() !== 71'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", observed());
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add_sub();
        bit ok;
        int lat;
        logic [70:0] exp;
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 4'h3, ok);
        wait_result(lat);
        exp = {64'h0, 1'b1, 1'b0, 1'b1, 4'h3};
        checks++;
        if (!ok || lat != 1) begin
            failures++;
            $display("FAIL add_latency: got ok=%0d lat=%0d want ok=1 lat=1", ok, lat);
        end
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL add_carry_zero: got %h want %h", observed(), exp);
        end
        take();

        issue(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 4'h5, ok);
        wait_result(lat);
        exp = {64'h0000_0000_8000_0000, 1'b0, 1'b1, 1'b0, 4'h5};
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL add_ovf: got %h want %h", observed(), exp);
        end
        take();

        issue(2'b01, 32'd5, 32'd7, 4'hA, ok);
        wait_result(lat);
        exp = {64'h0000_0000_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 4'hA};
        checks++;
        if (observed() !== exp || lat != 1) begin
            failures++;
            $display("FAIL sub_borrow: got %h lat=%0d want %h lat=1", observed(), lat, exp);
        end
        take();

        issue(2'b01, 32'h8000_0000, 32'd1, 4'h6, ok);
        wait_result(lat);
        exp = {64'h0000_0000_7FFF_FFFF, 1'b0, 1'b1, 1'b0, 4'h6};
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL sub_ovf: got %h want %h", observed(), exp);
        end
        take();
    endtask

    task automatic test_mul();
        bit ok;
        int lat;
        logic [70:0] exp;
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hC, ok);
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy_in_ready: got %b want 0", bus.in_ready);
        end
        wait_result(lat);
        exp = {64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0, 1'b0, 4'hC};
        checks++;
        if (lat != MUL_LAT) begin
            failures++;
            $display("FAIL mulu_latency: got %0d want %0d", lat, MUL_LAT);
        end
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL mulu_max: got %h want %h", observed(), exp);
        end
        take();

        issue(2'b11, 32'hFFFF_FFFD, 32'h0000_0005, 4'h1, ok);
        wait_result(lat);
        exp = {64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0, 1'b0, 4'h1};
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL muls_neg: got %h want %h", observed(), exp);
        end
        take();

        issue(2'b11, 32'h8000_0000, 32'h8000_0000, 4'h2, ok);
        wait_result(lat);
        exp = {64'h4000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 4'h2};
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL muls_minneg: got %h want %h", observed(), exp);
        end
        take();

        issue(2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 4'h4, ok);
        wait_result(lat);
        exp = {64'h0, 1'b0, 1'b0, 1'b1, 4'h4};
        checks++;
        if (observed() !== exp) begin
            failures++;
            $display("FAIL muls_zero: got %h want %h", observed(), exp);
        end
        take();
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [70:0] exp;
        exp = model(2'b00, 32'h1234_5678, 32'h4321_0FED, 4'h9);
        issue(2'b00, 32'h1234_5678, 32'h4321_0FED, 4'h9, ok);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (observed() !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: got %h v=%b rdy=%b want %h v=1 rdy=0",
                         i, observed(), bus.out_valid, bus.in_ready, exp);
            end
            @(negedge clk);
        end
        take();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release: got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_mul();
        bit ok;
        int lat;
        bit seen;
        issue(2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 4'h7, ok);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (observed() !== 71'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_mul_reset: got %h v=%b rdy=%b want 0 v=0 rdy=1",
                     observed(), bus.out_valid, bus.in_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < MUL_LAT + 5; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL dropped_op: got out_valid=1 want no result after reset");
        end
        issue(2'b00, 32'd2, 32'd3, 4'hE, ok);
        wait_result(lat);
        checks++;
        if (observed() !== {64'd5, 1'b0, 1'b0, 1'b0, 4'hE} || lat != 1) begin
            failures++;
            $display("FAIL add_after_reset: got %h lat=%0d want 5 lat=1", observed(), lat);
        end
        take();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        logic [70:0] exp;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            logic [3:0] t;
            o = 2'(i);
            a = $urandom;
            b = $urandom;
            t = 4'(i + 8);
            exp = model(o, a, b, t);
            issue(o, a, b, t, ok);
            wait_result(lat);
            checks++;
            if (observed() !== exp || lat != (o[1] ? MUL_LAT : 1)) begin
                failures++;
                $display("FAIL b2b_%0d: got %h lat=%0d want %h", i, observed(), lat, exp);
            end
            take();
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_bubble_%0d: got rdy=%b v=%b want rdy=1 v=0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        logic [70:0] exp;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            logic [3:0] t;
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            t = 4'($urandom);
            exp = model(o, a, b, t);
            issue(o, a, b, t, ok);
            wait_result(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            $display("txn %0d op=%0d a=%h b=%h tag=%h res=%h lat=%0d",
                     i, o, a, b, t, bus.ALU_Out, lat);
            checks++;
            if (!ok || observed() !== exp || lat != (o[1] ? MUL_LAT : 1)) begin
                failures++;
                $display("FAIL rand_%0d: got %h lat=%0d want %h lat=%0d",
                         i, observed(), lat, exp, (o[1] ? MUL_LAT : 1));
            end
            take();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.A         = '0;
        bus.B         = '0;
        bus.tag_in    = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
